ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the EX stage. Consumes the register operands
//  delivered by the ID/EX pipeline register (RData1_Ex, RData2_Ex). Executes
//  MULT/MULTU/DIV/DIVU over multiple cycles and writes the HI/LO result registers.
//  Busy is used by hazard logic to stall the front end until the result is available.
// PARAMETERS
//  WIDTH  32  operand width; iteration count = WIDTH
// PORTS
//  Clk        in   1      clock; rising edge
//  Rst_n      in   1      asynchronous, active-low reset
//  Start      in   1      request; sampled only while Busy=0
//  Op         in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  RData1_Ex  in   WIDTH  operand A (multiplicand / dividend)
//  RData2_Ex  in   WIDTH  operand B (multiplier / divisor)
//  Flush      in   1      abort the operation in flight (branch/exception squash)
//  Busy       out  1      operation in progress
//  Done       out  1      one-cycle pulse; Hi/Lo valid from this cycle
//  Hi         out  WIDTH  product[2W-1:W] / remainder
//  Lo         out  WIDTH  product[W-1:0] / quotient
//  DivByZero  out  1      last DIV/DIVU had B==0; held until next accepted Start
// BEHAVIOUR
//  Reset (Rst_n=0, any time, including mid-operation): state=IDLE.
//   Busy=0, Done=0, Hi=0, Lo=0, DivByZero=0, all internal registers cleared.
//  FSM states: IDLE -> CALC -> FIX -> IDLE.
//  IDLE, Start=1 at edge E0:
//   - Capture Op.
//   - Capture |A| and |B| (two's-complement magnitude for signed ops, raw for unsigned).
//   - Capture result sign: A^B for the product/quotient; A for the remainder.
//   - Clear the iteration counter. state->CALC. Busy=1 and DivByZero=0 after E0.
//  CALC: one iteration per edge; WIDTH iterations (edges E1..E_WIDTH); then ->FIX.
//   - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
//   - Divide: restoring shift-subtract; remainder and quotient registers.
//  FIX, at edge E_WIDTH+1:
//   - Apply sign correction (negate if sign flag set) and write Hi/Lo.
//   - Done=1 for exactly one cycle, Busy=0, state->IDLE.
//   - Latency: Start edge to Done = WIDTH+1 edges (33 at default).
//  Hi/Lo change only at FIX; they hold the previous values throughout CALC.
//  Start while Busy=1: ignored; no queuing.
//  Start during the Done cycle: accepted (state is IDLE); Done still pulses once.
//  Flush while Busy=1:
//   - state->IDLE at the next edge; Hi/Lo/DivByZero unchanged; no Done pulse.
//   - Flush and Start in the same IDLE cycle: Flush wins; the Start is dropped.
//  Divide by zero (B==0, DIV/DIVU):
//   - Runs the full latency.
//   - Result: Lo=all ones, Hi=A (raw operand), DivByZero=1 at FIX.
//  Signed overflow DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0; no flag.
//  Signed remainder takes the sign of the dividend; quotient truncates toward zero.
//  All arithmetic is unsigned on magnitudes; the sign is restored only in FIX.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - Op encodings (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV).
//   - FSM state encodings.
//   - WIDTH-derived counter width.
//  One natural sub-module: muldiv_sign_fix (combinational).
//   - Operand magnitude conversion and result negation.
//   - Instantiated for the input side and the output side.
//  FSM, counter and shift datapath stay in ex_muldiv_unit.
// TESTING
//  1 MULTU A=0xFFFFFFFF B=2:
//    -> Done 33 edges after Start; Hi=0x00000001, Lo=0xFFFFFFFE.
//  2 MULT A=0xFFFFFFFD(-3) B=7:
//    -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
//  3 DIV A=0xFFFFFFF9(-7) B=2:
//    -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
//    DIVU A=100 B=7:
//    -> Lo=14, Hi=2.
//  4 DIVU A=0x1234 B=0:
//    -> Lo=0xFFFFFFFF, Hi=0x1234, DivByZero=1.
//    Next Start:
//    -> DivByZero=0 after that edge.
//  5 Start MULT; Flush at edge 10:
//    -> Busy=0 next edge, no Done, Hi/Lo keep prior values.
//    Second Start pulsed mid-operation:
//    -> ignored; exactly one Done per accepted Start.
//  6 Rst_n driven low asynchronously mid-CALC:
//    -> Busy/Done/Hi/Lo/DivByZero = 0 immediately.
//    New Start after release:
//    -> completes normally with the correct result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;

    // Counter holds iteration index 0..w-1.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: operand magnitude on the way in,
// sign restoration on the way out.
module muldiv_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] val,
    input  logic             neg,
    output logic [WIDTH-1:0] res
);

    assign res = neg ? ('0 - val) : val;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one radix-2 step per cycle on magnitudes,
// sign correction and HI/LO write in a final fix-up cycle.
module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] RData1_Ex,
    input  logic [WIDTH-1:0] RData2_Ex,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               sign_q, sign_r;

    logic [WIDTH-1:0]   a_abs, b_abs, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix, acc_nxt;
    logic [WIDTH:0]     mul_sum, div_tmp, div_diff;
    logic               div_ge;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_a_abs (
        .val(RData1_Ex), .neg(Op[0] & RData1_Ex[WIDTH-1]), .res(a_abs));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_b_abs (
        .val(RData2_Ex), .neg(Op[0] & RData2_Ex[WIDTH-1]), .res(b_abs));

    muldiv_sign_fix #(.WIDTH(2*WIDTH)) u_prod_fix (
        .val(acc), .neg(sign_q), .res(prod_fix));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_quot_fix (
        .val(acc[WIDTH-1:0]), .neg(sign_q), .res(quot_fix));
    muldiv_sign_fix #(.WIDTH(WIDTH)) u_rem_fix (
        .val(acc[2*WIDTH-1:WIDTH]), .neg(sign_r), .res(rem_fix));

    // acc = {partial product high, multiplier bits} for multiply,
    //       {partial remainder, dividend/quotient bits} for divide.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, a_mag & {WIDTH{acc[0]}}};
    assign div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = (div_tmp >= {1'b0, b_mag});
    assign div_diff = div_tmp - {1'b0, b_mag};
    assign acc_nxt  = op_q[1]
        ? {(div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0]), acc[WIDTH-2:0], div_ge}
        : {mul_sum, acc[WIDTH-1:1]};

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            acc       <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            DivByZero <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Flush) begin
                // Squash wins over everything, including a same-cycle Start.
                state <= ST_IDLE;
                Busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (Start) begin
                        op_q      <= Op;
                        a_mag     <= a_abs;
                        b_mag     <= b_abs;
                        acc       <= Op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                        sign_q    <= Op[0] & (RData1_Ex[WIDTH-1] ^ RData2_Ex[WIDTH-1]);
                        sign_r    <= Op[0] & RData1_Ex[WIDTH-1];
                        cnt       <= '0;
                        Busy      <= 1'b1;
                        DivByZero <= 1'b0;
                        state     <= ST_CALC;
                    end
                    ST_CALC: begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (op_q[1]) begin
                            // Zero divisor leaves remainder = |A|, so re-signing yields raw A.
                            Lo        <= (b_mag == '0) ? '1 : quot_fix;
                            Hi        <= rem_fix;
                            DivByZero <= (b_mag == '0);
                        end else begin
                            {Hi, Lo}  <= prod_fix;
                        end
                        Done  <= 1'b1;
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized self-checking bench for ex_muldiv_unit against an arithmetic reference.
module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] RData1_Ex = '0;
    logic [31:0] RData2_Ex = '0;
    logic        Flush = 1'b0;
    logic        Busy, Done, DivByZero;
    logic [31:0] Hi, Lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    logic        exp_dbz = 1'b0;

    ex_muldiv_unit #(.WIDTH(32)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op),
        .RData1_Ex(RData1_Ex), .RData2_Ex(RData2_Ex), .Flush(Flush),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .DivByZero(DivByZero));

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        logic [63:0] p;
        longint sa, sb, q, r;
        dbz = 1'b0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            OP_MULT:  begin p = 64'(sa * sb);            hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 0) begin
                    lo = '1; hi = a; dbz = 1'b1;
                end else if (op == OP_DIVU) begin
                    lo = a / b; hi = a % b;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lo = q[31:0]; hi = r[31:0];
                end
            end
        endcase
    endtask

    // Issue one op, check acceptance, hold of Hi/Lo during CALC, latency and result.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] mh, ml;
        logic        md;
        int n;
        model(op, a, b, mh, ml, md);
        @(negedge Clk);
        Start = 1'b1; Op = op; RData1_Ex = a; RData2_Ex = b;
        @(posedge Clk); #1;
        Start = 1'b0;
        chk("busy_after_start", Busy, 1);
        chk("dbz_cleared", DivByZero, 0);
        n = 0;
        while (!Done && n < 100) begin
            @(posedge Clk); #1;
            n++;
            if (n == 16) begin
                chk("hold_hi", Hi, exp_hi);
                chk("hold_lo", Lo, exp_lo);
            end
        end
        chk("latency", n, 33);
        chk("hi", Hi, mh);
        chk("lo", Lo, ml);
        chk("dbz", DivByZero, md);
        chk("busy_at_done", Busy, 0);
        exp_hi = mh; exp_lo = ml; exp_dbz = md;
    endtask

    initial begin
        logic [31:0] mh, ml;
        logic        md;
        int nd;

        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_hi", Hi, 0);
        chk("rst_lo", Lo, 0);
        chk("rst_dbz", DivByZero, 0);
        @(negedge Clk); Rst_n = 1'b1;

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        @(posedge Clk); #1;
        chk("done_pulse", Done, 0);
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_op(OP_DIVU, 32'd100, 32'd7);
        run_op(OP_DIVU, 32'h1234, 32'd0);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);

        // Flush at edge 10 of a MULT: no Done, results untouched.
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULT; RData1_Ex = 32'd123; RData2_Ex = 32'd456;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (8) @(posedge Clk);
        #1; Flush = 1'b1;
        @(posedge Clk); #1; Flush = 1'b0;
        chk("flush_busy", Busy, 0);
        nd = 0;
        repeat (40) begin @(posedge Clk); #1; if (Done) nd++; end
        chk("flush_no_done", nd, 0);
        chk("flush_hi", Hi, exp_hi);
        chk("flush_lo", Lo, exp_lo);
        chk("flush_dbz", DivByZero, exp_dbz);

        // Start and Flush together in IDLE: Start dropped.
        @(negedge Clk); Start = 1'b1; Flush = 1'b1;
        @(posedge Clk); #1; Start = 1'b0; Flush = 1'b0;
        chk("flush_start_busy", Busy, 0);

        // Second Start mid-operation is ignored.
        model(OP_MULTU, 32'd1000, 32'd3000, mh, ml, md);
        @(negedge Clk);
        Start = 1'b1; Op = OP_MULTU; RData1_Ex = 32'd1000; RData2_Ex = 32'd3000;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (5) @(posedge Clk);
        #1; Start = 1'b1; Op = OP_DIVU; RData1_Ex = 32'd77; RData2_Ex = 32'd5;
        @(posedge Clk); #1; Start = 1'b0;
        nd = 0;
        repeat (60) begin @(posedge Clk); #1; if (Done) nd++; end
        chk("ignored_start_ndone", nd, 1);
        chk("ignored_start_hi", Hi, mh);
        chk("ignored_start_lo", Lo, ml);
        exp_hi = mh; exp_lo = ml; exp_dbz = md;

        // Back-to-back: second Start lands in the Done cycle.
        run_op(OP_DIVU, 32'd1000, 32'd9);
        run_op(OP_MULT, 32'hFFFF_FF00, 32'h0000_0100);

        // Asynchronous reset mid-CALC.
        @(negedge Clk);
        Start = 1'b1; Op = OP_DIV; RData1_Ex = 32'd999; RData2_Ex = 32'd0;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (12) @(posedge Clk);
        #3; Rst_n = 1'b0;
        #1;
        chk("arst_busy", Busy, 0);
        chk("arst_done", Done, 0);
        chk("arst_hi", Hi, 0);
        chk("arst_lo", Lo, 0);
        chk("arst_dbz", DivByZero, 0);
        exp_hi = '0; exp_lo = '0; exp_dbz = 1'b0;
        @(negedge Clk); Rst_n = 1'b1;
        run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = b & 32'hFF;
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
